// File: rtl/memory_demux.sv
// Dual-bank writer for SHA-256 A..H state: one staged write commits to bank 1 or 2, init loads the IV into both.
// Optional feed-forward accumulate (bank += input) is built only when MEMORY_DEMUX_ACCUM_EN is defined.
module memory_demux #(
  parameter bit RST_LOAD_IV = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        addr,
  input  logic        wr_acc,
  input  logic [31:0] in_A,
  input  logic [31:0] in_B,
  input  logic [31:0] in_C,
  input  logic [31:0] in_D,
  input  logic [31:0] in_E,
  input  logic [31:0] in_F,
  input  logic [31:0] in_G,
  input  logic [31:0] in_H,
  output logic [31:0] out_A_1,
  output logic [31:0] out_B_1,
  output logic [31:0] out_C_1,
  output logic [31:0] out_D_1,
  output logic [31:0] out_E_1,
  output logic [31:0] out_F_1,
  output logic [31:0] out_G_1,
  output logic [31:0] out_H_1,
  output logic [31:0] out_A_2,
  output logic [31:0] out_B_2,
  output logic [31:0] out_C_2,
  output logic [31:0] out_D_2,
  output logic [31:0] out_E_2,
  output logic [31:0] out_F_2,
  output logic [31:0] out_G_2,
  output logic [31:0] out_H_2,
  output logic [1:0]  bank_valid
);

  typedef enum logic [1:0] {IDLE, INIT, COMMIT} state_t;

  // Packed so that IV[0] is word A and IV[7] is word H.
  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  state_t      state_q;
  logic [31:0] bank1_q  [8];
  logic [31:0] bank2_q  [8];
  logic [31:0] stage_q  [8];
  logic [31:0] commit_d [8];
  logic [31:0] in_w     [8];
  logic        stage_addr_q;
  logic [1:0]  bank_valid_q;

  function automatic logic [31:0] rst_word(input logic [2:0] idx);
    return RST_LOAD_IV ? IV[idx] : 32'h0;
  endfunction

  assign in_w[0] = in_A;
  assign in_w[1] = in_B;
  assign in_w[2] = in_C;
  assign in_w[3] = in_D;
  assign in_w[4] = in_E;
  assign in_w[5] = in_F;
  assign in_w[6] = in_G;
  assign in_w[7] = in_H;

  assign wr_ready = (state_q == IDLE) & ~init;

`ifdef MEMORY_DEMUX_ACCUM_EN
  logic stage_acc_q;

  // Per-word add, carry out of each word discarded.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      commit_d[i[2:0]] = stage_q[i[2:0]];
      if (stage_acc_q)
        commit_d[i[2:0]] = (stage_addr_q ? bank2_q[i[2:0]] : bank1_q[i[2:0]]) + stage_q[i[2:0]];
    end
  end
`else
  logic unused_acc;
  assign unused_acc = wr_acc;

  always_comb begin
    for (int i = 0; i < 8; i++) commit_d[i[2:0]] = stage_q[i[2:0]];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      stage_addr_q <= 1'b0;
      bank_valid_q <= 2'b00;
`ifdef MEMORY_DEMUX_ACCUM_EN
      stage_acc_q  <= 1'b0;
`endif
      for (int i = 0; i < 8; i++) begin
        bank1_q[i[2:0]] <= rst_word(i[2:0]);
        bank2_q[i[2:0]] <= rst_word(i[2:0]);
        stage_q[i[2:0]] <= 32'h0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (init) begin
            state_q <= INIT;
          end else if (wr_valid && wr_ready) begin
            stage_addr_q <= addr;
`ifdef MEMORY_DEMUX_ACCUM_EN
            stage_acc_q  <= wr_acc;
`endif
            for (int i = 0; i < 8; i++) stage_q[i[2:0]] <= in_w[i[2:0]];
            state_q <= COMMIT;
          end
        end
        INIT: begin
          for (int i = 0; i < 8; i++) begin
            bank1_q[i[2:0]] <= IV[i[2:0]];
            bank2_q[i[2:0]] <= IV[i[2:0]];
          end
          bank_valid_q <= 2'b11;
          state_q      <= IDLE;
        end
        COMMIT: begin
          if (stage_addr_q) begin
            for (int i = 0; i < 8; i++) bank2_q[i[2:0]] <= commit_d[i[2:0]];
            bank_valid_q[1] <= 1'b1;
          end else begin
            for (int i = 0; i < 8; i++) bank1_q[i[2:0]] <= commit_d[i[2:0]];
            bank_valid_q[0] <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_A_1 = bank1_q[0];
  assign out_B_1 = bank1_q[1];
  assign out_C_1 = bank1_q[2];
  assign out_D_1 = bank1_q[3];
  assign out_E_1 = bank1_q[4];
  assign out_F_1 = bank1_q[5];
  assign out_G_1 = bank1_q[6];
  assign out_H_1 = bank1_q[7];
  assign out_A_2 = bank2_q[0];
  assign out_B_2 = bank2_q[1];
  assign out_C_2 = bank2_q[2];
  assign out_D_2 = bank2_q[3];
  assign out_E_2 = bank2_q[4];
  assign out_F_2 = bank2_q[5];
  assign out_G_2 = bank2_q[6];
  assign out_H_2 = bank2_q[7];
  assign bank_valid = bank_valid_q;

endmodule

// File: tb/tb_memory_demux.sv
// Directed bench for memory_demux: reset (both RST_LOAD_IV values), init, overwrite, accumulate, collision, mid-op reset.
module tb_memory_demux;

  logic        clk = 1'b0;
  logic        rst, init, wr_valid, addr, wr_acc;
  logic [31:0] in_w [8];
  logic [31:0] o1 [8];
  logic [31:0] o2 [8];
  logic [31:0] p1 [8];
  logic [31:0] p2 [8];
  logic [1:0]  bv, bv_iv;
  logic        rdy, rdy_iv;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] ivt  [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  logic [31:0] set1 [8] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                            32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
  logic [31:0] set2 [8] = '{32'ha0000000, 32'ha0000001, 32'ha0000002, 32'ha0000003,
                            32'ha0000004, 32'ha0000005, 32'ha0000006, 32'ha0000007};
  logic [31:0] set3 [8] = '{32'hc0000000, 32'hc0000001, 32'hc0000002, 32'hc0000003,
                            32'hc0000004, 32'hc0000005, 32'hc0000006, 32'hc0000007};

  always #5 clk = ~clk;

  memory_demux dut (
    .clk(clk), .rst(rst), .init(init), .wr_valid(wr_valid), .wr_ready(rdy),
    .addr(addr), .wr_acc(wr_acc),
    .in_A(in_w[0]), .in_B(in_w[1]), .in_C(in_w[2]), .in_D(in_w[3]),
    .in_E(in_w[4]), .in_F(in_w[5]), .in_G(in_w[6]), .in_H(in_w[7]),
    .out_A_1(o1[0]), .out_B_1(o1[1]), .out_C_1(o1[2]), .out_D_1(o1[3]),
    .out_E_1(o1[4]), .out_F_1(o1[5]), .out_G_1(o1[6]), .out_H_1(o1[7]),
    .out_A_2(o2[0]), .out_B_2(o2[1]), .out_C_2(o2[2]), .out_D_2(o2[3]),
    .out_E_2(o2[4]), .out_F_2(o2[5]), .out_G_2(o2[6]), .out_H_2(o2[7]),
    .bank_valid(bv)
  );

  memory_demux #(.RST_LOAD_IV(1'b1)) dut_iv (
    .clk(clk), .rst(rst), .init(init), .wr_valid(wr_valid), .wr_ready(rdy_iv),
    .addr(addr), .wr_acc(wr_acc),
    .in_A(in_w[0]), .in_B(in_w[1]), .in_C(in_w[2]), .in_D(in_w[3]),
    .in_E(in_w[4]), .in_F(in_w[5]), .in_G(in_w[6]), .in_H(in_w[7]),
    .out_A_1(p1[0]), .out_B_1(p1[1]), .out_C_1(p1[2]), .out_D_1(p1[3]),
    .out_E_1(p1[4]), .out_F_1(p1[5]), .out_G_1(p1[6]), .out_H_1(p1[7]),
    .out_A_2(p2[0]), .out_B_2(p2[1]), .out_C_2(p2[2]), .out_D_2(p2[3]),
    .out_E_2(p2[4]), .out_F_2(p2[5]), .out_G_2(p2[6]), .out_H_2(p2[7]),
    .bank_valid(bv_iv)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic init_pulse;
    init = 1'b1;
    tick();
    init = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; init = 1'b0; wr_valid = 1'b0; addr = 1'b0; wr_acc = 1'b0;
    for (int i = 0; i < 8; i++) in_w[i[2:0]] = 32'h0;
    #2 rst = 1'b1;
    tick();
    tick();

    // Reset state, both reset-value variants
    for (int i = 0; i < 8; i++) begin
      check_eq("rst_b1", o1[i[2:0]], 32'h0);
      check_eq("rst_b2", o2[i[2:0]], 32'h0);
      check_eq("rst_iv_b1", p1[i[2:0]], ivt[i[2:0]]);
      check_eq("rst_iv_b2", p2[i[2:0]], ivt[i[2:0]]);
    end
    check_eq("rst_bv", {30'h0, bv}, 32'h0);
    check_eq("rst_iv_bv", {30'h0, bv_iv}, 32'h0);
    check_eq("rst_rdy", {31'h0, rdy}, 32'h1);
    init = 1'b1;
    #1 check_eq("rst_rdy_init", {31'h0, rdy}, 32'h0);
    init = 1'b0;
    rst = 1'b0;
    tick();

    // Init pulse: ready low in the pulse cycle and the INIT cycle
    init = 1'b1;
    #1 check_eq("init_rdy_c0", {31'h0, rdy}, 32'h0);
    tick();
    init = 1'b0;
    #1 check_eq("init_rdy_c1", {31'h0, rdy}, 32'h0);
    check_eq("init_b1_not_yet", o1[0], 32'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check_eq("init_b1", o1[i[2:0]], ivt[i[2:0]]);
      check_eq("init_b2", o2[i[2:0]], ivt[i[2:0]]);
    end
    check_eq("init_bv", {30'h0, bv}, 32'h3);
    check_eq("init_rdy_after", {31'h0, rdy}, 32'h1);

    // Overwrite bank 2 with wr_valid held; inputs change during COMMIT
    addr = 1'b1; wr_acc = 1'b0; wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) in_w[i[2:0]] = set1[i[2:0]];
    tick();
    for (int i = 0; i < 8; i++) in_w[i[2:0]] = set2[i[2:0]];
    #1 check_eq("ow_rdy_commit", {31'h0, rdy}, 32'h0);
    check_eq("ow_b2_not_yet", o2[0], ivt[0]);
    tick();
    for (int i = 0; i < 8; i++) begin
      check_eq("ow_b2_set1", o2[i[2:0]], set1[i[2:0]]);
      check_eq("ow_b1_keep", o1[i[2:0]], ivt[i[2:0]]);
    end
    check_eq("ow_rdy_idle", {31'h0, rdy}, 32'h1);
    tick();
    check_eq("ow_rdy_2nd", {31'h0, rdy}, 32'h0);
    wr_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) check_eq("ow_b2_set2", o2[i[2:0]], set2[i[2:0]]);
    check_eq("ow_bv", {30'h0, bv}, 32'h3);

    // Accumulate into bank 1 after a fresh init
    init_pulse();
    addr = 1'b0; wr_acc = 1'b1; wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) in_w[i[2:0]] = 32'h0;
    in_w[0] = 32'h95f6199a;
    tick();
    wr_valid = 1'b0; wr_acc = 1'b0;
    tick();
`ifdef MEMORY_DEMUX_ACCUM_EN
    check_eq("acc_A_wrap", o1[0], 32'h00000001);
    for (int i = 1; i < 8; i++) check_eq("acc_keep_iv", o1[i[2:0]], ivt[i[2:0]]);
`else
    check_eq("acc_A_ovw", o1[0], 32'h95f6199a);
    for (int i = 1; i < 8; i++) check_eq("acc_ovw_zero", o1[i[2:0]], 32'h0);
`endif
    check_eq("acc_b2_iv", o2[0], ivt[0]);

    // Collision: init and write together, write lands after the IV
    init = 1'b1; wr_valid = 1'b1; addr = 1'b0;
    for (int i = 0; i < 8; i++) in_w[i[2:0]] = set3[i[2:0]];
    #1 check_eq("col_rdy", {31'h0, rdy}, 32'h0);
    tick();
    init = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) check_eq("col_b1_iv", o1[i[2:0]], ivt[i[2:0]]);
    check_eq("col_rdy_idle", {31'h0, rdy}, 32'h1);
    tick();
    wr_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) check_eq("col_b1_wr", o1[i[2:0]], set3[i[2:0]]);

    // Reset asserted while a bank 1 commit is pending
    wr_valid = 1'b1; addr = 1'b0;
    for (int i = 0; i < 8; i++) in_w[i[2:0]] = set1[i[2:0]];
    tick();
    wr_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("mid_b1", o1[0], 32'h0);
    check_eq("mid_bv", {30'h0, bv}, 32'h0);
    check_eq("mid_rdy", {31'h0, rdy}, 32'h1);
    tick();
    rst = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) check_eq("mid_no_commit", o1[i[2:0]], 32'h0);
    check_eq("mid_bv_after", {30'h0, bv}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/memory_demux.md
# memory_demux

Dual-bank writer for the SHA-256 working/digest state (eight 32-bit words A..H); the write-side counterpart to the bank read switch. It accepts one A..H word set through a valid/ready handshake and commits it into bank 1 or bank 2, selected by `addr`. It also holds both banks and drives them continuously to the downstream read switch. An `init` command loads the SHA-256 initial hash value into both banks, and an optional accumulate mode performs the digest feed-forward (bank += input, mod 2^32).

## Interface
- `RST_LOAD_IV`, default 0: bank contents after reset. 0 = all words 0x00000000; 1 = SHA-256 IV. `bank_valid` resets to 2'b00 in both cases.
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous active-high reset
- `init`  in  1  load IV into both banks (single-cycle pulse; level re-triggers)
- `wr_valid`  in  1  write request
- `wr_ready`  out  1  block can accept a write this cycle
- `addr`  in  1  target bank: 0 → bank 1, 1 → bank 2 (sampled with the write)
- `wr_acc`  in  1  accumulate instead of overwrite (effective only with the macro)
- `in_A` .. `in_H`  in  32 each  word set to write
- `out_A_1` .. `out_H_1`  out  32 each  bank 1 contents (registered)
- `out_A_2` .. `out_H_2`  out  32 each  bank 2 contents (registered)
- `bank_valid`  out  2  bit0 = bank 1 written or initialised since reset; bit1 = bank 2

## Operation
- FSM states: IDLE, INIT, COMMIT. Reset state is IDLE.
- `wr_ready` = (state == IDLE) & ~`init`, combinational.
- **IDLE:**
  - `init`=1 → INIT (takes priority over `wr_valid`).
  - else `wr_valid` & `wr_ready` → capture `in_A..in_H`, `addr` and `wr_acc` into staging registers; go to COMMIT.
  - else stay in IDLE.
- **INIT:** both banks ← IV (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19 for A..H); `bank_valid` ← 2'b11; go to IDLE.
- **COMMIT:**
  - Selected bank ← staged words, or (bank + staged) per word if accumulating.
  - `bank_valid[staged addr]` ← 1; the other bank is untouched; go to IDLE.
- Arithmetic: 32-bit unsigned per word, carry discarded (wraps mod 2^32). There is no carry between words.
- Accumulating into a bank with `bank_valid` bit = 0 adds to the current contents (0 after reset, or the IV if `RST_LOAD_IV`=1). This is not an error.
- Input changes outside the accept cycle have no effect; staging isolates the banks from the input bus.
- Reset mid-INIT or mid-COMMIT: the operation is discarded; banks, `bank_valid` and FSM take their reset values immediately.

## Timing
- Write latency: accepted at rising edge k (IDLE→COMMIT). The new bank value is visible on `out_*` after edge k+1.
- Throughput: one write per 2 cycles. `wr_ready` is low during COMMIT and INIT.
- Init latency: `init` sampled at edge k; IV is visible on both banks after edge k+1. `wr_ready` is low in the `init` cycle and in the INIT cycle.
- Back-to-back `wr_valid` held high: accepts occur at k, k+2, k+4, ...
- All outputs except `wr_ready` are registered. During `rst`, `wr_ready` = ~`init`.

## Configuration
- `MEMORY_DEMUX_ACCUM_EN` defined: `wr_acc`=1 in the accepted write selects accumulate; `wr_acc`=0 selects overwrite.
- Not defined: `wr_acc` is ignored, every commit is an overwrite, and no adders are synthesised. The port list is identical in both builds.

## Test plan
- **Reset:** `rst`=1 with `RST_LOAD_IV`=0 → all 16 output words 0x00000000, `bank_valid`=2'b00, `wr_ready`=1. With `RST_LOAD_IV`=1 → both banks show IV and `bank_valid`=2'b00.
- **Init:** one-cycle `init` pulse → after the next edge, `out_A_1`=`out_A_2`=0x6a09e667 … `out_H_*`=0x5be0cd19, `bank_valid`=2'b11, `wr_ready` low for 2 cycles.
- **Overwrite:** after init, write `addr`=1, `wr_acc`=0, in_A..in_H = 0x11111111..0x88888888 → bank 2 shows those values one edge after accept; bank 1 still holds IV; `bank_valid`=2'b11. Held `wr_valid` is accepted every 2nd cycle.
- **Accumulate:** after init, write `addr`=0, `wr_acc`=1, `in_A`=0x95f6199a, other words 0.
  - With the macro: `out_A_1`=0x00000001 (wrap) and `out_B_1`..`out_H_1` keep IV.
  - Without the macro: `out_A_1`=0x95f6199a and `out_B_1`..`out_H_1` = 0.
- **Collision:** `init`=1 and `wr_valid`=1 in the same IDLE cycle → `wr_ready`=0, write not captured, banks become IV. `wr_valid` held → write accepted 2 cycles later and committed after IV.
- **Reset mid-operation:** assert `rst` during COMMIT of a write to bank 1 → bank 1 reads 0x00000000, `bank_valid`=2'b00, FSM in IDLE, no commit after release.
